quad_step_decoder: RTL and testbench

QUAD_STEP_DECODER -- requirements
Module: quad_step_decoder

---
 rtl/quad_step_decoder.sv | 133 +++++++++++++
 tb/tb_quad_step_decoder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/quad_step_decoder.sv
// Quadrature step decoder: synchronizes and glitch-filters two phase inputs,
// decodes Gray-code steps into a wrapping position counter with event pulses.
module quad_step_decoder #(
  parameter int WIDTH  = 4,
  parameter int FILTER = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             qa,
  input  logic             qb,
  input  logic             clr,
  output logic [WIDTH-1:0] counter,
  output logic             dir,
  output logic             step,
  output logic             ovf,
  output logic             unf,
  output logic             err,
  output logic [3:0]       err_cnt
);

  // Difference of Gray positions (current - previous, mod 4) maps directly
  // onto the kind of move observed.
  typedef enum logic [1:0] {
    MOVE_NONE    = 2'd0,
    MOVE_UP      = 2'd1,
    MOVE_ILLEGAL = 2'd2,
    MOVE_DOWN    = 2'd3
  } move_t;

  localparam logic [3:0]       FILTER_LAST = 4'(FILTER - 1);
  localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);
  localparam logic [3:0]       ERR_MAX     = 4'hF;

  // Index 1 carries phase A, index 0 phase B, so {A,B} reads as a 2-bit pair.
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] filt;
  logic [1:0] prev;
  logic [3:0] filt_cnt [2];
  logic [1:0] delta;
  move_t      move;

  // Gray pair {A,B} to position along the up sequence 00,01,11,10.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

  // NOTE: state is assigned with <= so every flop samples pre-edge values;
  // blocking assignments here would collapse the synchronizer chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {qa, qb};
      sync2 <= sync1;
    end
  end

  // A phase level is adopted only after FILTER consecutive disagreeing samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt <= '0;
      for (int i = 0; i < 2; i++) filt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] == FILTER_LAST) begin
          filt[i]     <= sync2[i];
          filt_cnt[i] <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev <= '0;
    else        prev <= filt;
  end

  // NOTE: every always_comb output gets an unconditional value first, so no
  // path through the block can leave it holding and infer a latch.
  always_comb begin
    delta = gray_pos(filt) - gray_pos(prev);
    move  = move_t'(delta);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter <= '0;
      dir     <= 1'b0;
      step    <= 1'b0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      step <= 1'b0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
      err  <= 1'b0;
      if (clr) begin
        // Clear wins over any move decoded this cycle; dir is kept.
        counter <= '0;
        err_cnt <= '0;
      end else begin
        case (move)
          MOVE_UP: begin
            counter <= counter + ONE;
            dir     <= 1'b0;
            step    <= 1'b1;
            ovf     <= &counter;
          end
          MOVE_DOWN: begin
            counter <= counter - ONE;
            dir     <= 1'b1;
            step    <= 1'b1;
            unf     <= (counter == '0);
          end
          MOVE_ILLEGAL: begin
            err <= 1'b1;
            if (err_cnt != ERR_MAX) err_cnt <= err_cnt + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder: stepping, wrap, glitch filter,
// illegal transitions, clear collision and asynchronous reset.
module tb_quad_step_decoder;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       clr   = 1'b0;
  logic       qa2 = 1'b0, qb2 = 1'b0, qa3 = 1'b0, qb3 = 1'b0;

  logic [3:0] c2, ec2, c3, ec3;
  logic       dir2, step2, ovf2, unf2, err2;
  logic       dir3, step3, ovf3, unf3, err3;

  quad_step_decoder #(.WIDTH(4), .FILTER(2)) dut (
    .clk(clk), .reset(reset), .qa(qa2), .qb(qb2), .clr(clr),
    .counter(c2), .dir(dir2), .step(step2), .ovf(ovf2), .unf(unf2),
    .err(err2), .err_cnt(ec2)
  );

  quad_step_decoder #(.WIDTH(4), .FILTER(3)) dut_f3 (
    .clk(clk), .reset(reset), .qa(qa3), .qb(qb3), .clr(clr),
    .counter(c3), .dir(dir3), .step(step3), .ovf(ovf3), .unf(unf3),
    .err(err3), .err_cnt(ec3)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         pos      = 0;
  logic [3:0] m_cnt    = '0;
  logic       m_dir    = 1'b0;
  logic [3:0] m_ec     = '0;
  int         f_step, n_step, n_ovf, n_unf, n_err, f_err;
  int         excl_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Runs n cycles on the FILTER=2 instance, sampling 1 ns after each edge.
  task automatic run2(input int n);
    f_step = 0; n_step = 0; n_ovf = 0; n_unf = 0; n_err = 0; f_err = 0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      if (step2) begin n_step++; if (f_step == 0) f_step = k; end
      if (err2)  begin n_err++;  if (f_err == 0)  f_err = k;  end
      if (ovf2) n_ovf++;
      if (unf2) n_unf++;
      if ((step2 && err2) || (ovf2 && unf2)) excl_bad++;
    end
  endtask

  task automatic drive2(input int p);
    logic [1:0] g;
    logic [1:0] b;
    pos = p % 4;
    b   = 2'(pos);
    g   = {b[1], b[1] ^ b[0]};
    qa2 = g[1];
    qb2 = g[0];
  endtask

  task automatic up_step(input string tag);
    logic wrap;
    wrap = (m_cnt == 4'hF);
    drive2(pos + 1);
    run2(8);
    m_cnt = m_cnt + 4'd1;
    m_dir = 1'b0;
    check({tag, "_lat"},   f_step, 5);
    check({tag, "_steps"}, n_step, 1);
    check({tag, "_cnt"},   c2, m_cnt);
    check({tag, "_dir"},   dir2, m_dir);
    check({tag, "_ovf"},   n_ovf, wrap ? 1 : 0);
    check({tag, "_unf"},   n_unf, 0);
  endtask

  task automatic down_step(input string tag);
    logic wrap;
    wrap = (m_cnt == 4'h0);
    drive2(pos + 3);
    run2(8);
    m_cnt = m_cnt - 4'd1;
    m_dir = 1'b1;
    check({tag, "_lat"},   f_step, 5);
    check({tag, "_steps"}, n_step, 1);
    check({tag, "_cnt"},   c2, m_cnt);
    check({tag, "_dir"},   dir2, m_dir);
    check({tag, "_unf"},   n_unf, wrap ? 1 : 0);
    check({tag, "_ovf"},   n_ovf, 0);
  endtask

  task automatic illegal_step(input string tag);
    drive2(pos + 2);
    run2(8);
    if (m_ec != 4'hF) m_ec = m_ec + 4'd1;
    check({tag, "_err"},   n_err, 1);
    check({tag, "_lat"},   f_err, 5);
    check({tag, "_steps"}, n_step, 0);
    check({tag, "_cnt"},   c2, m_cnt);
    check({tag, "_dir"},   dir2, m_dir);
    check({tag, "_ecnt"},  ec2, m_ec);
  endtask

  initial begin
    int s3, u3, o3;

    // Reset held low across several edges.
    repeat (3) @(posedge clk);
    #1;
    check("rst_cnt",  c2, 0);
    check("rst_dir",  dir2, 0);
    check("rst_step", step2, 0);
    check("rst_ovf",  ovf2, 0);
    check("rst_unf",  unf2, 0);
    check("rst_err",  err2, 0);
    check("rst_ecnt", ec2, 0);
    reset = 1'b1;
    run2(10);
    check("idle_steps", n_step, 0);
    check("idle_err",   n_err, 0);
    check("idle_cnt",   c2, 0);

    // Glitch filter on the FILTER=3 instance: 2-cycle pulse rejected.
    qa3 = 1'b1;
    repeat (2) @(posedge clk);
    #1; qa3 = 1'b0;
    s3 = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (step3) s3++;
    end
    check("glitch2_steps", s3, 0);
    check("glitch2_cnt",   c3, 0);

    // 3-cycle pulse accepted: down to 15 on the rising level, up to 0 on return.
    qa3 = 1'b1;
    repeat (3) @(posedge clk);
    #1; qa3 = 1'b0;
    s3 = 0; u3 = 0; o3 = 0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      if (step3) s3++;
      if (unf3)  u3++;
      if (ovf3)  o3++;
    end
    check("glitch3_steps", s3, 2);
    check("glitch3_unf",   u3, 1);
    check("glitch3_ovf",   o3, 1);
    check("glitch3_cnt",   c3, 0);
    check("glitch3_dir",   dir3, 0);

    // Up stepping 01, 11, 10, 00.
    up_step("up1");
    up_step("up2");
    up_step("up3");
    up_step("up4");
    for (int i = 5; i <= 15; i++) up_step($sformatf("up%0d", i));
    check("at_max", c2, 15);
    up_step("wrap_up");
    down_step("wrap_down");

    // Illegal transitions, saturating the error count.
    for (int i = 1; i <= 16; i++) illegal_step($sformatf("ill%0d", i));
    check("ecnt_sat", ec2, 15);

    // Clear lands on the same edge that would register a pending up step.
    drive2(pos + 1);
    repeat (4) @(posedge clk);
    #1; clr = 1'b1;
    @(posedge clk);
    #1; clr = 1'b0;
    check("clr_cnt",  c2, 0);
    check("clr_ecnt", ec2, 0);
    check("clr_step", step2, 0);
    check("clr_ovf",  ovf2, 0);
    check("clr_dir",  dir2, m_dir);
    m_cnt = '0;
    m_ec  = '0;
    run2(6);
    check("clr_after_steps", n_step, 0);
    up_step("post_clr");

    // Build a non-trivial state (counter 7, dir down, one error).
    illegal_step("pre_rst_ill");
    for (int i = 0; i < 7; i++) up_step($sformatf("pre_rst_up%0d", i));
    down_step("pre_rst_down");
    check("pre_rst_cnt", c2, 7);

    // Asynchronous reset between edges; qa=qb=1 applied while held.
    @(posedge clk);
    #3; reset = 1'b0;
    #1;
    check("arst_cnt",  c2, 0);
    check("arst_dir",  dir2, 0);
    check("arst_step", step2, 0);
    check("arst_ovf",  ovf2, 0);
    check("arst_unf",  unf2, 0);
    check("arst_err",  err2, 0);
    check("arst_ecnt", ec2, 0);
    qa2 = 1'b1; qb2 = 1'b1;
    repeat (3) @(posedge clk);
    #1; reset = 1'b1;
    run2(12);
    check("rel11_err",   n_err, 1);
    check("rel11_lat",   f_err, 5);
    check("rel11_ecnt",  ec2, 1);
    check("rel11_steps", n_step, 0);
    check("rel11_cnt",   c2, 0);

    check("exclusive", excl_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
